rpn_eval: RTL and testbench

Postfix (RPN) expression evaluator that drives a stack as its push/pop master. Consumes a valid/ready token stream of operands and operators, issues push and pop commands to an external `stack` instance, and returns one result or one error per expression. Sits between the token source and the stack: the command-issuing end of the stack's `wn`/`rn`/`in`/`out`/`full`/`empty` interface.

---
 rtl/rpn_eval.sv | 271 +++++++++++++++++++++++++++
 tb/tb_rpn_eval.sv | 316 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rpn_eval.sv
// -----------------------------------------------------------------------------
// rpn_eval
// Postfix (RPN) expression evaluator. It takes operands and operators from a
// valid/ready token stream and acts as the push/pop master of an external
// stack. For each expression it returns either one result or one error.
//
// Ports
//   clk        rising-edge clock
//   rst        synchronous active-high reset. The attached stack's rst_n is
//              driven from the inverse of this signal.
//   tok_valid  token present
//   tok_ready  token accepted when tok_valid & tok_ready (high only in IDLE)
//   tok_is_op  1 = operator, 0 = operand
//   tok_data   operand value, or opcode in [1:0]: 0 ADD, 1 SUB, 2 MUL, 3 END
//   stk_push   stack write command (stack wn)
//   stk_pop    stack read/remove command (stack rn)
//   stk_din    word written on push (stack in)
//   stk_top    top-of-stack word, valid whenever stk_empty is 0 (stack out)
//   stk_full   stack full flag
//   stk_empty  stack empty flag
//   res_valid  one-cycle result strobe
//   res_data   result, held until the next res_valid
//   err_valid  one-cycle strobe at the end of an error flush
//   err_code   1 overflow, 2 underflow, 3 leftover operands; held until the
//              next err_valid
// -----------------------------------------------------------------------------
module rpn_eval #(
   parameter int DATA_WIDTH  = 16,
   parameter int STACK_DEPTH = 16
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  tok_valid,
   output logic                  tok_ready,
   input  logic                  tok_is_op,
   input  logic [DATA_WIDTH-1:0] tok_data,
   output logic                  stk_push,
   output logic                  stk_pop,
   output logic [DATA_WIDTH-1:0] stk_din,
   input  logic [DATA_WIDTH-1:0] stk_top,
   input  logic                  stk_full,
   input  logic                  stk_empty,
   output logic                  res_valid,
   output logic [DATA_WIDTH-1:0] res_data,
   output logic                  err_valid,
   output logic [1:0]            err_code
);

   // A binary operator pops two entries and then pushes one. That is only
   // safe with room for at least two entries.
   if (STACK_DEPTH < 2) begin : g_depth_check
      $error("rpn_eval: STACK_DEPTH must be at least 2");
   end

   localparam logic [1:0] OP_ADD   = 2'd0;
   localparam logic [1:0] OP_SUB   = 2'd1;
   localparam logic [1:0] OP_MUL   = 2'd2;
   localparam logic [1:0] OP_END   = 2'd3;

   localparam logic [1:0] ERR_NONE = 2'd0;
   localparam logic [1:0] ERR_OVF  = 2'd1;
   localparam logic [1:0] ERR_UDF  = 2'd2;
   localparam logic [1:0] ERR_LEFT = 2'd3;

   typedef enum logic [3:0] {
      S_IDLE  = 4'd0,
      S_POP_B = 4'd1,
      S_POP_A = 4'd2,
      S_EXEC  = 4'd3,
      S_PUSH  = 4'd4,
      S_POP_R = 4'd5,
      S_CHECK = 4'd6,
      S_DONE  = 4'd7,
      S_FLUSH = 4'd8
   } state_t;

   state_t                state_r;
   state_t                state_s;
   logic [1:0]            op_r;
   logic [DATA_WIDTH-1:0] a_r;
   logic [DATA_WIDTH-1:0] b_r;
   logic [DATA_WIDTH-1:0] r_r;
   logic [DATA_WIDTH-1:0] res_data_r;
   logic [1:0]            err_code_r;

   logic                  tok_ready_s;
   logic                  stk_push_s;
   logic                  stk_pop_s;
   logic [DATA_WIDTH-1:0] stk_din_s;
   logic                  res_valid_s;
   logic                  err_valid_s;

   // Arithmetic wraps modulo 2**DATA_WIDTH. No saturation, no carry flag.
   function automatic logic [DATA_WIDTH-1:0] alu(
      input logic [1:0]            op,
      input logic [DATA_WIDTH-1:0] a,
      input logic [DATA_WIDTH-1:0] b
   );
      logic [DATA_WIDTH-1:0] y;
      case (op)
         OP_ADD:  y = a + b;
         OP_SUB:  y = a - b;
         OP_MUL:  y = DATA_WIDTH'(a * b);
         default: y = '0;
      endcase
      return y;
   endfunction

   // Next-state and command decode. Every output is forced quiet during reset.
   always_comb begin
      state_s     = state_r;
      tok_ready_s = 1'b0;
      stk_push_s  = 1'b0;
      stk_pop_s   = 1'b0;
      stk_din_s   = '0;
      res_valid_s = 1'b0;
      err_valid_s = 1'b0;
      if (rst) begin
         state_s = S_IDLE;
      end else begin
         case (state_r)
            S_IDLE: begin
               tok_ready_s = 1'b1;
               if (tok_valid) begin
                  if (!tok_is_op) begin
                     if (!stk_full) begin
                        stk_push_s = 1'b1;
                        stk_din_s  = tok_data;
                     end else begin
                        state_s = S_FLUSH;
                     end
                  end else if (tok_data[1:0] == OP_END) begin
                     state_s = S_POP_R;
                  end else begin
                     state_s = S_POP_B;
                  end
               end else begin
                  state_s = S_IDLE;
               end
            end
            S_POP_B: begin
               if (stk_empty) begin
                  state_s = S_FLUSH;
               end else begin
                  stk_pop_s = 1'b1;
                  state_s   = S_POP_A;
               end
            end
            S_POP_A: begin
               if (stk_empty) begin
                  state_s = S_FLUSH;
               end else begin
                  stk_pop_s = 1'b1;
                  state_s   = S_EXEC;
               end
            end
            S_EXEC: begin
               state_s = S_PUSH;
            end
            S_PUSH: begin
               // The stack has room here, because two entries were just popped.
               stk_push_s = 1'b1;
               stk_din_s  = r_r;
               state_s    = S_IDLE;
            end
            S_POP_R: begin
               if (stk_empty) begin
                  state_s = S_FLUSH;
               end else begin
                  stk_pop_s = 1'b1;
                  state_s   = S_CHECK;
               end
            end
            S_CHECK: begin
               if (stk_empty) begin
                  state_s = S_DONE;
               end else begin
                  state_s = S_FLUSH;
               end
            end
            S_DONE: begin
               res_valid_s = 1'b1;
               state_s     = S_IDLE;
            end
            S_FLUSH: begin
               // Drain the stack one entry per cycle. Report once it is empty.
               if (stk_empty) begin
                  err_valid_s = 1'b1;
                  state_s     = S_IDLE;
               end else begin
                  stk_pop_s = 1'b1;
               end
            end
            default: begin
               state_s = S_IDLE;
            end
         endcase
      end
   end

   // State register and datapath registers (operands, result, status).
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r    <= S_IDLE;
         op_r       <= OP_ADD;
         a_r        <= '0;
         b_r        <= '0;
         r_r        <= '0;
         res_data_r <= '0;
         err_code_r <= ERR_NONE;
      end else begin
         state_r <= state_s;
         case (state_r)
            S_IDLE: begin
               if (tok_valid && tok_is_op) begin
                  op_r <= tok_data[1:0];
               end else if (tok_valid && !tok_is_op && stk_full) begin
                  err_code_r <= ERR_OVF;
               end else begin
                  op_r <= op_r;
               end
            end
            S_POP_B: begin
               if (stk_empty) begin
                  err_code_r <= ERR_UDF;
               end else begin
                  b_r <= stk_top;
               end
            end
            S_POP_A: begin
               if (stk_empty) begin
                  err_code_r <= ERR_UDF;
               end else begin
                  a_r <= stk_top;
               end
            end
            S_EXEC: begin
               r_r <= alu(op_r, a_r, b_r);
            end
            S_POP_R: begin
               if (stk_empty) begin
                  err_code_r <= ERR_UDF;
               end else begin
                  r_r <= stk_top;
               end
            end
            S_CHECK: begin
               // Load the result while entering DONE, so it lines up with res_valid.
               if (stk_empty) begin
                  res_data_r <= r_r;
               end else begin
                  err_code_r <= ERR_LEFT;
               end
            end
            default: begin
               r_r <= r_r;
            end
         endcase
      end
   end

   assign tok_ready = tok_ready_s;
   assign stk_push  = stk_push_s;
   assign stk_pop   = stk_pop_s;
   assign stk_din   = stk_din_s;
   assign res_valid = res_valid_s;
   assign err_valid = err_valid_s;
   assign res_data  = res_data_r;
   assign err_code  = err_code_r;

endmodule

// File: tb/tb_rpn_eval.sv
// -----------------------------------------------------------------------------
// tb_rpn_eval
// Self-checking bench for rpn_eval. A 16-entry behavioural stack is attached
// to the DUT. Each token sent is also fed to a queue-based postfix evaluator.
// When that evaluator completes an expression, it pushes the expected result
// or error onto a scoreboard queue. A monitor pops that queue whenever the DUT
// strobes res_valid or err_valid.
// -----------------------------------------------------------------------------
module tb_rpn_eval;
   localparam int DW    = 16;
   localparam int DEPTH = 16;

   logic          clk = 1'b0;
   logic          rst;
   logic          tok_valid;
   logic          tok_ready;
   logic          tok_is_op;
   logic [DW-1:0] tok_data;
   logic          stk_push;
   logic          stk_pop;
   logic [DW-1:0] stk_din;
   logic [DW-1:0] stk_top;
   logic          stk_full;
   logic          stk_empty;
   logic          res_valid;
   logic [DW-1:0] res_data;
   logic          err_valid;
   logic [1:0]    err_code;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   rpn_eval #(.DATA_WIDTH(DW), .STACK_DEPTH(DEPTH)) dut (
      .clk(clk), .rst(rst),
      .tok_valid(tok_valid), .tok_ready(tok_ready), .tok_is_op(tok_is_op), .tok_data(tok_data),
      .stk_push(stk_push), .stk_pop(stk_pop), .stk_din(stk_din), .stk_top(stk_top),
      .stk_full(stk_full), .stk_empty(stk_empty),
      .res_valid(res_valid), .res_data(res_data),
      .err_valid(err_valid), .err_code(err_code)
   );

   // Behavioural stack: top visible combinationally, push/pop at the edge.
   logic [DW-1:0] smem [0:DEPTH-1];
   logic [4:0]    scnt;
   int            push_cnt;
   int            pop_cnt;
   assign stk_empty = (scnt == 5'd0);
   assign stk_full  = (scnt == 5'(DEPTH));
   assign stk_top   = stk_empty ? '0 : smem[4'(scnt - 5'd1)];

   always @(posedge clk) begin
      if (rst) begin
         scnt <= 5'd0;
      end else if (stk_push && !stk_pop && !stk_full) begin
         smem[scnt[3:0]] <= stk_din;
         scnt            <= scnt + 5'd1;
         push_cnt        <= push_cnt + 1;
      end else if (stk_pop && !stk_push && !stk_empty) begin
         scnt    <= scnt - 5'd1;
         pop_cnt <= pop_cnt + 1;
      end
   end

   // Scoreboard. bit16 = 1 means error (code in [1:0]); otherwise it is a result value.
   logic [16:0] sbq[$];
   logic [DW-1:0] mstk[$];
   logic [DW-1:0] last_res = '0;
   logic [1:0]    last_err = 2'd0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   // Reference evaluator. It applies the postfix rules directly to a queue.
   task automatic model_tok(input bit is_op, input logic [DW-1:0] d);
      logic [DW-1:0] a, b, r;
      if (!is_op) begin
         if (mstk.size() == DEPTH) begin
            sbq.push_back({1'b1, 14'd0, 2'd1});
            mstk.delete();
         end else begin
            mstk.push_back(d);
         end
      end else if (d[1:0] == 2'd3) begin
         if (mstk.size() == 0) begin
            sbq.push_back({1'b1, 14'd0, 2'd2});
         end else if (mstk.size() > 1) begin
            sbq.push_back({1'b1, 14'd0, 2'd3});
            mstk.delete();
         end else begin
            r = mstk.pop_back();
            sbq.push_back({1'b0, r});
         end
      end else begin
         if (mstk.size() < 2) begin
            sbq.push_back({1'b1, 14'd0, 2'd2});
            mstk.delete();
         end else begin
            b = mstk.pop_back();
            a = mstk.pop_back();
            case (d[1:0])
               2'd0:    r = a + b;
               2'd1:    r = a - b;
               default: r = DW'(a * b);
            endcase
            mstk.push_back(r);
         end
      end
   endtask

   // Present a token and hold it until the DUT accepts it. Returns at edge+1.
   task automatic send_tok(input bit is_op, input logic [DW-1:0] d);
      int n = 0;
      model_tok(is_op, d);
      tok_valid = 1'b1;
      tok_is_op = is_op;
      tok_data  = d;
      while (!tok_ready && n < 200) begin
         @(posedge clk); #1;
         n++;
      end
      if (n >= 200) begin
         checks++;
         failures++;
         $display("FAIL tok_accept_timeout: got ready=0 expected ready=1");
      end
      @(posedge clk); #1;
      tok_valid = 1'b0;
   endtask

   task automatic opnd(input logic [DW-1:0] v);
      send_tok(1'b0, v);
   endtask

   task automatic opr(input logic [1:0] code);
      logic [DW-1:0] d;
      d = {14'($urandom), code};
      send_tok(1'b1, d);
   endtask

   task automatic drain();
      int n = 0;
      while (sbq.size() != 0 && n < 300) begin
         @(posedge clk); #1;
         n++;
      end
      if (n >= 300) begin
         checks++;
         failures++;
         $display("FAIL drain_timeout: got pending=%0d expected pending=0", sbq.size());
      end
      @(posedge clk); #1;
   endtask

   // Monitor: compare every result or error strobe, and check the stack protocol.
   always @(negedge clk) begin
      logic [16:0] e;
      if (!rst) begin
         if (stk_push || stk_pop) begin
            checks++;
            if ((stk_push && stk_pop) || (stk_push && stk_full) || (stk_pop && stk_empty)) begin
               failures++;
               $display("FAIL stack_protocol: got push=%0b pop=%0b full=%0b empty=%0b expected legal command",
                        stk_push, stk_pop, stk_full, stk_empty);
            end
         end
         if (res_valid || err_valid) begin
            checks++;
            if (res_valid && err_valid) begin
               failures++;
               $display("FAIL strobe_both: got res_valid=1 err_valid=1 expected one");
            end else if (sbq.size() == 0) begin
               failures++;
               $display("FAIL unexpected_strobe: got res=%0b err=%0b expected none", res_valid, err_valid);
            end else begin
               e = sbq.pop_front();
               if (e[16]) begin
                  last_err = e[1:0];
                  if (!err_valid || err_code !== e[1:0]) begin
                     failures++;
                     $display("FAIL scoreboard_err: got err_valid=%0b code=%0d expected err code=%0d",
                              err_valid, err_code, e[1:0]);
                  end
               end else begin
                  last_res = e[15:0];
                  if (!res_valid || res_data !== e[15:0]) begin
                     failures++;
                     $display("FAIL scoreboard_res: got res_valid=%0b data=0x%0h expected result 0x%0h",
                              res_valid, res_data, e[15:0]);
                  end
               end
            end
         end
      end
   end

   initial begin
      int p0, q0, gap;
      int r;
      rst       = 1'b1;
      tok_valid = 1'b0;
      tok_is_op = 1'b0;
      tok_data  = '0;
      push_cnt  = 0;
      pop_cnt   = 0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("reset_tok_ready", 32'(tok_ready), 32'd0);
      chk("reset_cmds", {28'd0, stk_push, stk_pop, res_valid, err_valid}, 32'd0);
      chk("reset_res_data", 32'(res_data), 32'd0);
      chk("reset_err_code", 32'(err_code), 32'd0);
      chk("reset_stk_din", 32'(stk_din), 32'd0);
      @(posedge clk); #1;
      rst = 1'b0;
      #1;
      chk("ready_after_reset", 32'(tok_ready), 32'd1);

      // Simple add, with command counts.
      p0 = push_cnt; q0 = pop_cnt;
      opnd(16'd3); opnd(16'd4); opr(2'd0); opr(2'd3);
      drain();
      chk("add_result", 32'(res_data), 32'd7);
      chk("add_push_count", 32'(push_cnt - p0), 32'd3);
      chk("add_pop_count", 32'(pop_cnt - q0), 32'd3);
      chk("add_stack_empty", 32'(stk_empty), 32'd1);

      // Nested expression: 5 1 2 + 4 * + 3 - = 14.
      opnd(16'd5); opnd(16'd1); opnd(16'd2); opr(2'd0); opnd(16'd4); opr(2'd2);
      opr(2'd0); opnd(16'd3); opr(2'd1); opr(2'd3);
      drain();
      chk("nested_result", 32'(res_data), 32'h000E);

      // Wrap-around cases.
      opnd(16'h8000); opnd(16'd2); opr(2'd2); opr(2'd3);
      drain();
      chk("wrap_mul", 32'(res_data), 32'h0000);
      opnd(16'd0); opnd(16'd1); opr(2'd1); opr(2'd3);
      drain();
      chk("wrap_sub", 32'(res_data), 32'hFFFF);
      opnd(16'hFFFF); opnd(16'd1); opr(2'd0); opr(2'd3);
      drain();
      chk("wrap_add", 32'(res_data), 32'h0000);

      // Underflow, then recovery.
      opnd(16'd3); opr(2'd0);
      drain();
      chk("underflow_code", 32'(err_code), 32'd2);
      chk("underflow_empty", 32'(stk_empty), 32'd1);
      opnd(16'd6); opnd(16'd6); opr(2'd0); opr(2'd3);
      drain();
      chk("after_underflow", 32'(res_data), 32'd12);

      // Overflow: 17 operands at depth 16. FLUSH performs all 16 pops.
      q0 = pop_cnt;
      for (int i = 1; i <= DEPTH + 1; i++) opnd(16'(i));
      drain();
      chk("overflow_code", 32'(err_code), 32'd1);
      chk("overflow_flush_pops", 32'(pop_cnt - q0), 32'd16);
      chk("overflow_empty", 32'(stk_empty), 32'd1);

      // Leftover: POP_R removes one entry, then FLUSH removes the other.
      q0 = pop_cnt;
      opnd(16'd1); opnd(16'd2); opr(2'd3);
      drain();
      chk("leftover_code", 32'(err_code), 32'd3);
      chk("leftover_pops", 32'(pop_cnt - q0), 32'd2);

      // Reset during POP_A of 9 8 SUB. No strobe may follow.
      opnd(16'd9); opnd(16'd8); opr(2'd1);
      @(posedge clk); #1;
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      mstk.delete();
      #1;
      chk("ready_after_midreset", 32'(tok_ready), 32'd1);
      opnd(16'd2); opnd(16'd3); opr(2'd2); opr(2'd3);
      drain();
      chk("after_midreset", 32'(res_data), 32'd6);

      // Randomized token stream, with idle gaps.
      for (int t = 0; t < 400; t++) begin
         r = $urandom_range(0, 99);
         if (r < 55) begin
            if ($urandom_range(0, 3) == 0) opnd(16'($urandom));
            else opnd(16'($urandom_range(0, 20)));
         end else if (r < 85) begin
            opr(2'($urandom_range(0, 2)));
         end else begin
            opr(2'd3);
         end
         if ($urandom_range(0, 3) == 0) begin
            gap = $urandom_range(1, 3);
            repeat (gap) begin
               @(posedge clk); #1;
            end
         end
      end
      opr(2'd3);
      drain();
      chk("final_stack_empty", 32'(stk_empty), 32'd1);
      chk("res_data_held", 32'(res_data), 32'(last_res));
      chk("err_code_held", 32'(err_code), 32'(last_err));
      chk("scoreboard_empty", 32'(sbq.size()), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
